// File: rtl/write_buffer_if.sv
// Write-buffer bus: cache write port, read-miss forwarding lookup and RAM write port.
// Latency: none; this is a bundle of wires.
// Backpressure: wr_ready (write side) and mem_busy (RAM side) travel in this bundle.
//
// Port summary:
//   wr_req/wr_addr/wr_data/wr_ready    cache -> buffer write handshake
//   rd_addr/rd_fwd_hit/rd_fwd_data     read-miss forwarding lookup
//   mem_busy/mem_we/mem_addr/mem_wdata buffer -> RAM drain port
// master = cache/RAM environment, slave = write_buffer.
interface write_buffer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  logic [ADDR_W-1:0] rd_addr;
  logic              rd_fwd_hit;
  logic [DATA_W-1:0] rd_fwd_data;

  logic              mem_busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output wr_req, wr_addr, wr_data, rd_addr, mem_busy,
    input  wr_ready, rd_fwd_hit, rd_fwd_data, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_addr, mem_busy,
    output wr_ready, rd_fwd_hit, rd_fwd_data, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/write_buffer.sv
// Write-through store buffer between the direct-mapped cache and RAM, with read-miss forwarding.
// Latency: a write accepted at edge N can reach mem_we in the cycle after edge N; forwarding is combinational.
// Backpressure: wr_ready drops when full or flushing; mem_busy stalls the drain with all state held.
//
// Ports: clk, rst_n (synchronous, active low); bus (write_buffer_if.slave: wr_*, rd_*, mem_*);
//        flush_req in, flush_done one-cycle pulse out, count/empty occupancy out.
// Optional feature: define WBUF_COALESCE_EN to merge writes into an already-buffered entry
// with the same address instead of allocating a new one.
module write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  write_buffer_if.slave        bus,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                 empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // FIFO storage and pointers
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // control FSM
  state_t state_q, state_d;
  logic   flush_done_q, flush_done_d;

  logic             wr_rdy;
  logic             accept;
  logic             push;
  logic             pop;
  logic             co_hit;
  logic [PTR_W-1:0] co_idx;
  logic             fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign flush_done = flush_done_q;

  // Drain: the head entry is always on the RAM port; the strobe is suppressed
  // while reset is asserted so a reset edge never commits a write to RAM.
  assign pop           = rst_n & ~empty & ~bus.mem_busy;
  assign bus.mem_we    = pop;
  assign bus.mem_addr  = addr_q[head_q];
  assign bus.mem_wdata = data_q[head_q];

  // Forwarding: scan from oldest (head) to youngest so the last match wins.
  // Entries pushed this cycle are not yet valid and therefore not forwarded;
  // the head being popped this cycle is still valid and still forwards.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (addr_q[idx] == bus.rd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  assign bus.rd_fwd_hit  = fwd_hit;
  assign bus.rd_fwd_data = fwd_data;

`ifdef WBUF_COALESCE_EN
  // Merge target: youngest valid entry with the same address, excluding a head
  // that leaves this cycle (writing into it would be lost once it drains).
  always_comb begin
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (addr_q[idx] == bus.wr_addr) && !(pop && (idx == head_q))) begin
        co_hit = 1'b1;
        co_idx = idx;
      end
    end
  end

  // A merge needs no free slot, so it is accepted even when full.
  assign wr_rdy = ((count_q < CNT_W'(DEPTH)) | co_hit) & (state_q == ST_RUN);
`else
  assign co_hit = 1'b0;
  assign co_idx = '0;

  // Space freed by a same-cycle pop is not reused, keeping mem_busy off this path.
  assign wr_rdy = (count_q < CNT_W'(DEPTH)) & (state_q == ST_RUN);
`endif

  assign bus.wr_ready = wr_rdy;
  assign accept       = bus.wr_req & wr_rdy;
  assign push         = accept & ~co_hit;

  // Next-state for the FIFO
  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    head_d = head_q;
    tail_d = tail_q;

    if (pop) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end

    if (accept && co_hit) begin
      data_d[co_idx] = bus.wr_data;
    end

    // push implies count < DEPTH, so the tail slot is free even with a pop pending
    if (push) begin
      vld_d[tail_q]  = 1'b1;
      addr_d[tail_q] = bus.wr_addr;
      data_d[tail_q] = bus.wr_data;
      tail_d         = tail_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next-state for the FSM. flush_done is registered: it is asserted for the
  // FLUSH cycle in which the buffer is empty, i.e. the cycle before RUN resumes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_req) state_d = ST_FLUSH;
      ST_FLUSH: if (empty)     state_d = ST_RUN;
      default:                 state_d = ST_RUN;
    endcase
    flush_done_d = (state_d == ST_FLUSH) && (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: every slot is qualified by its valid bit.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= flush_done_d;
    end
  end

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush_req;
  logic       flush_done;
  logic [2:0] count;
  logic       empty;

  write_buffer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  write_buffer #(.DEPTH(DEPTH), .ADDR_W(8), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .count      (count),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t sb_q[$];      // writes the RAM still has to receive, oldest first
  logic m_flush = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   flush_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: inputs were set after the previous edge; sample at negedge,
  // compare against the scoreboard, then advance the model across the edge.
  task automatic step();
    int         n;
    int         idx;
    logic       exp_we;
    logic       exp_rdy;
    logic       match;
    logic       hit;
    logic [7:0] fd;

    @(negedge clk);
    n      = sb_q.size();
    exp_we = rst_n && (n > 0) && !bus.mem_busy;

    match = 1'b0;
    idx   = 0;
    for (int i = (exp_we ? 1 : 0); i < n; i++) begin
      if (sb_q[i].a == bus.wr_addr) begin
        match = 1'b1;
        idx   = i;
      end
    end
`ifdef WBUF_COALESCE_EN
    exp_rdy = !m_flush && ((n < DEPTH) || match);
`else
    match   = 1'b0;
    exp_rdy = !m_flush && (n < DEPTH);
`endif

    hit = 1'b0;
    fd  = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (sb_q[i].a == bus.rd_addr) begin
        hit = 1'b1;
        fd  = sb_q[i].d;
      end
    end

    chk("mem_we", bus.mem_we, exp_we);
    if (exp_we) begin
      chk("mem_addr", bus.mem_addr, sb_q[0].a);
      chk("mem_wdata", bus.mem_wdata, sb_q[0].d);
    end

    if (rst_n) begin
      chk("count", count, n);
      chk("empty", empty, n == 0);
      chk("wr_ready", bus.wr_ready, exp_rdy);
      chk("flush_done", flush_done, m_flush && (n == 0));
      chk("fwd_hit", bus.rd_fwd_hit, hit);
      if (hit) chk("fwd_data", bus.rd_fwd_data, fd);
      if (flush_done === 1'b1) flush_pulses++;
    end

    if (!rst_n) begin
      sb_q.delete();
      m_flush = 1'b0;
    end else begin
      if (exp_we) begin
        void'(sb_q.pop_front());
        idx--;
      end
      if (bus.wr_req && exp_rdy) begin
        if (match) sb_q[idx].d = bus.wr_data;
        else       sb_q.push_back('{a: bus.wr_addr, d: bus.wr_data});
      end
      if (!m_flush && flush_req)     m_flush = 1'b1;
      else if (m_flush && (n == 0))  m_flush = 1'b0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    step();
    bus.wr_req  = 1'b0;
  endtask

  task automatic drain();
    bus.mem_busy = 1'b0;
    bus.wr_req   = 1'b0;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
    step();
    chk("drained", empty, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    flush_req    = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_addr  = 8'h00;
    bus.wr_data  = 8'h00;
    bus.rd_addr  = 8'hFF;
    bus.mem_busy = 1'b0;

    // reset, then idle state
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", bus.wr_ready, 1'b1);

    // fill while stalled; fifth write refused; full-buffer merge on 0x12
    bus.mem_busy = 1'b1;
    wr(8'h10, 8'hAA);
    wr(8'h11, 8'hBB);
    wr(8'h12, 8'hCC);
    wr(8'h13, 8'hDD);
    wr(8'h14, 8'hEE);
    wr(8'h12, 8'h5C);
    for (int i = 0; i < 3; i++) step();
    drain();

    // forwarding of duplicate address, youngest wins
    bus.mem_busy = 1'b1;
    wr(8'h20, 8'h01);
    wr(8'h20, 8'h02);
    bus.rd_addr = 8'h20;
    step();
    chk("fwd_young", bus.rd_fwd_data, 8'h02);
    bus.rd_addr = 8'h21;
    step();
`ifdef WBUF_COALESCE_EN
    chk("dup_count", count, 3'd1);
`else
    chk("dup_count", count, 3'd2);
`endif
    drain();

    // write to the address of the head that drains this very cycle
    bus.mem_busy = 1'b1;
    wr(8'h30, 8'h11);
    bus.mem_busy = 1'b0;
    bus.rd_addr  = 8'h30;
    wr(8'h30, 8'h22);
    drain();
    bus.rd_addr = 8'hFF;

    // steady push+pop with pointer wrap
    bus.mem_busy = 1'b1;
    wr(8'h40, 8'h80);
    wr(8'h41, 8'h81);
    bus.mem_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.rd_addr = 8'h42 + 8'(i) - 8'd1;
      wr(8'h42 + 8'(i), 8'h82 + 8'(i));
    end
    chk("wrap_count", count, 3'd2);
    drain();

    // flush with three entries, writes held off during the flush
    bus.mem_busy = 1'b1;
    wr(8'h50, 8'h01);
    wr(8'h51, 8'h02);
    wr(8'h52, 8'h03);
    flush_pulses = 0;
    flush_req    = 1'b1;
    step();
    flush_req    = 1'b0;
    chk("flush_rdy0", bus.wr_ready, 1'b0);
    step();
    bus.mem_busy = 1'b0;
    for (int i = 0; i < 6; i++) wr(8'h58, 8'h99);
    chk("flush_pulses", flush_pulses, 1);
    drain();

    // flush with an already-empty buffer
    flush_pulses = 0;
    flush_req    = 1'b1;
    step();
    flush_req    = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("flush_empty_pulses", flush_pulses, 1);

    // reset while a drain is in progress
    bus.mem_busy = 1'b1;
    wr(8'h60, 8'h01);
    wr(8'h61, 8'h02);
    wr(8'h62, 8'h03);
    bus.mem_busy = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rst_mid_empty", empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
